// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: mul/div FSM encoding,
// stall counter limit and the register-dependency compare.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_e;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // r0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle mul/div sequencer: launches the unit, holds the pipeline for
// MD_LATENCY cycles, then lets the mul/div instruction advance.
module muldiv_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_req,
    input  logic hold,
    output logic md_start,
    output logic md_busy,
    output logic md_stall
);

    localparam logic [3:0] CNT_INIT = 4'(MD_LATENCY - 2);

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_start = 1'b0;
        md_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    md_stall = 1'b1;
                    // Another hazard blocks the launch; retry once it clears.
                    if (!hold) begin
                        md_start = 1'b1;
                        state_d  = BUSY;
                        cnt_d    = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                md_stall = 1'b1;
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DONE: begin
                if (!hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign md_busy = (state_q == BUSY);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-operand and mul/div stalls,
// branch/jump flush, and a saturating stall-cycle counter.
module hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ID_RegRs,
    input  logic [4:0]  ID_RegRt,
    input  logic        ID_UsesRt,
    input  logic        ID_Branch,
    input  logic        ID_BranchTaken,
    input  logic        ID_Jump,
    input  logic        ID_MulDiv,
    input  logic        EX_MemRead,
    input  logic        EX_RegWrite,
    input  logic [4:0]  EX_RegRd,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_RegRd,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        MD_Start,
    output logic        MD_Busy,
    output logic [15:0] StallCount
);

    logic ex_match, mem_match;
    logic load_use, branch_stall, md_stall, stall;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        ex_match     = reg_match(EX_RegRd, ID_RegRs, ID_RegRt, ID_UsesRt);
        mem_match    = reg_match(MEM_RegRd, ID_RegRs, ID_RegRt, ID_UsesRt);
        load_use     = EX_MemRead & ex_match;
        // Branches resolve in ID, so they also wait on an ALU result in EX
        // and on a load still in MEM.
        branch_stall = ID_Branch & ((EX_RegWrite & ex_match) | (MEM_MemRead & mem_match));
    end

    muldiv_seq #(
        .MD_LATENCY(MD_LATENCY)
    ) u_muldiv_seq (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_req(ID_MulDiv),
        .hold     (load_use | branch_stall),
        .md_start (MD_Start),
        .md_busy  (MD_Busy),
        .md_stall (md_stall)
    );

    always_comb begin
        stall       = load_use | branch_stall | md_stall;
        PC_Write    = ~stall;
        IFID_Write  = ~stall;
        IDEX_Bubble = stall;
        IFID_Flush  = (ID_BranchTaken | ID_Jump) & ~stall;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != STALL_CNT_MAX)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    assign StallCount = stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) stall_cnt_q <= 16'd0;
        else        stall_cnt_q <= stall_cnt_d;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model predictions per cycle,
// a monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  ID_RegRs, ID_RegRt, EX_RegRd, MEM_RegRd;
    logic        ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump, ID_MulDiv;
    logic        EX_MemRead, EX_RegWrite, MEM_MemRead;
    logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Start, MD_Busy;
    logic [15:0] StallCount;

    hazard_ctrl #(.MD_LATENCY(LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
        .ID_MulDiv(ID_MulDiv), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
        .EX_RegRd(EX_RegRd), .MEM_MemRead(MEM_MemRead), .MEM_RegRd(MEM_RegRd),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .MD_Start(MD_Start), .MD_Busy(MD_Busy),
        .StallCount(StallCount)
    );

    always #5 clk_i = ~clk_i;

    // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Start, MD_Busy, StallCount}
    logic [21:0] exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model: mul/div owes a number of stall cycles after launch,
    // then waits for a stall-free cycle before the next launch is allowed.
    int busy_left = 0;
    bit done_wait = 1'b0;
    int stalls    = 0;

    function automatic bit dep(input logic [4:0] d, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt);
        return (d != 0) && (d == rs || (urt && d == rt));
    endfunction

    task automatic drive(input bit rst_n, input logic [4:0] rs, input logic [4:0] rt,
                         input bit urt, input bit br, input bit tk, input bit jmp,
                         input bit md, input bit exmr, input bit exrw,
                         input logic [4:0] exrd, input bit memmr, input logic [4:0] memrd);
        bit hold, busy, mds, start, stl;
        @(posedge clk_i);
        #1;
        rst_i = rst_n; ID_RegRs = rs; ID_RegRt = rt; ID_UsesRt = urt;
        ID_Branch = br; ID_BranchTaken = tk; ID_Jump = jmp; ID_MulDiv = md;
        EX_MemRead = exmr; EX_RegWrite = exrw; EX_RegRd = exrd;
        MEM_MemRead = memmr; MEM_RegRd = memrd;
        if (!rst_n) begin
            busy_left = 0; done_wait = 1'b0; stalls = 0;
        end
        hold  = (exmr && dep(exrd, rs, rt, urt)) ||
                (br && ((exrw && dep(exrd, rs, rt, urt)) || (memmr && dep(memrd, rs, rt, urt))));
        busy  = busy_left > 0;
        mds   = busy || (!done_wait && md);
        start = !busy && !done_wait && md && !hold;
        stl   = hold || mds;
        exp_q.push_back({!stl, !stl, (tk || jmp) && !stl, stl, start, busy, 16'(stalls)});
        if (rst_n) begin
            if (stl && stalls < 65535) stalls++;
            if (start) busy_left = LAT - 1;
            else if (busy) begin
                busy_left--;
                if (busy_left == 0) done_wait = 1'b1;
            end else if (done_wait && !stl) done_wait = 1'b0;
        end
    endtask

    task automatic idle_cyc(input bit rst_n);
        drive(rst_n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        logic [21:0] got, want;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Start, MD_Busy, StallCount};
                n_chk++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got pcw/ifw/fl/bub/st/bsy=%b cnt=%0d want %b cnt=%0d",
                             $time, got[21:16], got[15:0], want[21:16], want[15:0]);
                end
            end
        end
    end

    initial begin : stim
        rst_i = 1'b1;
        ID_RegRs = 0; ID_RegRt = 0; ID_UsesRt = 0; ID_Branch = 0; ID_BranchTaken = 0;
        ID_Jump = 0; ID_MulDiv = 0; EX_MemRead = 0; EX_RegWrite = 0; EX_RegRd = 0;
        MEM_MemRead = 0; MEM_RegRd = 0;
        #2 rst_i = 1'b0;
        idle_cyc(0); idle_cyc(0);
        idle_cyc(1);
        // load-use on r5
        drive(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0);
        idle_cyc(1); idle_cyc(1);
        // taken branch waiting on r8 in EX, then resolving
        drive(1, 0, 8, 1, 1, 1, 0, 0, 0, 1, 8, 0, 0);
        drive(1, 0, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle_cyc(1);
        // mul/div held until released, then the next instruction
        for (int i = 0; i < LAT + 1; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) idle_cyc(1);
        // r0 never matches
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 1, 0);
        // mul/div blocked by load-use, then launched
        drive(1, 3, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0);
        drive(1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // reset mid-BUSY
        drive(1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle_cyc(0);
        for (int i = 0; i < 3; i++) idle_cyc(1);
        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 99) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)));
        idle_cyc(0);
        // saturation
        for (int i = 0; i < 70000; i++) drive(1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0);
        idle_cyc(1);
        @(negedge clk_i);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, multiply/divide unit latency in cycles (legal 2..16).
REQ-002 SHALL have ports clk_i (in, 1, rising-edge clock) and rst_i (in, 1, asynchronous active-low reset).
REQ-003 SHALL have inputs ID_RegRs (5), ID_RegRt (5), ID_UsesRt (1), ID_Branch (1), ID_BranchTaken (1), ID_Jump (1) and ID_MulDiv (1), all describing the instruction in the ID stage.
REQ-004 SHALL have inputs EX_MemRead (1), EX_RegWrite (1), EX_RegRd (5), MEM_MemRead (1) and MEM_RegRd (5), all describing the instructions in the EX and MEM stages.
REQ-005 SHALL have outputs PC_Write (1), IFID_Write (1), IFID_Flush (1) and IDEX_Bubble (1), which drive the pipeline-register enables and squashes.
REQ-006 SHALL have outputs MD_Start (1), a one-cycle launch pulse to the mul/div unit, and MD_Busy (1).
REQ-007 SHALL have output StallCount (16), a registered count of stall cycles.

Function
REQ-008 SHALL define a match on a register as a non-zero destination that equals ID_RegRs, or equals ID_RegRt when ID_UsesRt=1.
REQ-009 SHALL raise a load-use stall when EX_MemRead=1 and EX_RegRd matches.
REQ-010 SHALL raise a branch-operand stall when ID_Branch=1 and either (EX_RegWrite=1 and EX_RegRd matches) or (MEM_MemRead=1 and MEM_RegRd matches).
REQ-011 SHALL raise a mul/div stall when the FSM is in state IDLE and ID_MulDiv=1, and also when the FSM is in state BUSY.
REQ-012 SHALL define stall as the OR of the three stall sources; while stall=1, PC_Write=0, IFID_Write=0 and IDEX_Bubble=1; otherwise PC_Write=1, IFID_Write=1 and IDEX_Bubble=0.
REQ-013 SHALL assert IFID_Flush=1 only when (ID_BranchTaken or ID_Jump) and stall=0, because stall has priority and the branch resolves again on the next cycle.
REQ-014 SHALL make all of PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble and MD_Start combinational from the inputs and the registered state, with zero latency.
REQ-015 SHALL implement an FSM with the states IDLE, BUSY and DONE, plus a 4-bit down-counter cnt.
REQ-016 SHALL, in state IDLE with ID_MulDiv=1 and no load-use or branch-operand stall, assert MD_Start=1 and move to BUSY next cycle with cnt=MD_LATENCY-2.
REQ-017 SHALL, in state IDLE with ID_MulDiv=1 while another stall source is active, keep MD_Start=0 and remain in IDLE.
REQ-018 SHALL, in state BUSY, decrement cnt each cycle and move to DONE on the cycle in which cnt=0; the launch cycle plus the BUSY cycles total MD_LATENCY stall cycles.
REQ-019 SHALL, in state DONE, ignore ID_MulDiv as a stall source and move to IDLE on the first cycle with stall=0 (the mul/div instruction advances); otherwise it remains in DONE.
REQ-020 SHALL assert MD_Busy=1 exactly when the state is BUSY, and SHALL assert MD_Start only in state IDLE.
REQ-021 SHALL increment StallCount on each rising edge sampled with stall=1, saturating at 16'hFFFF with no wrap.
REQ-022 SHALL never produce a stall from a match on register 0.

Reset
REQ-023 SHALL, while rst_i=0, immediately force the state to IDLE, cnt to 0 and StallCount to 0, regardless of the current clock phase.
REQ-024 SHALL, when reset is asserted in state BUSY or DONE, abandon the operation; MD_Start is not reissued until a fresh IDLE evaluation occurs after reset release.
REQ-025 SHALL, during reset with all inputs 0, drive PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, MD_Start=0 and MD_Busy=0.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the constant STALL_CNT_MAX=16'hFFFF in a shared package, cpu_ctrl_pkg.
REQ-027 SHALL implement the mul/div FSM and counter in one sub-module, muldiv_seq, with inputs start_req and hold and outputs md_start, md_busy and md_stall.
REQ-028 SHALL keep the hazard compare logic in the hazard_ctrl top level; it SHALL be purely combinational.

Verification
REQ-029 SHALL cover load-use: EX_MemRead=1, EX_RegRd=5, ID_RegRs=5 -> exactly one cycle with PC_Write=0, IDEX_Bubble=1, and StallCount=1.
REQ-030 SHALL cover a taken branch: ID_Branch=1, ID_BranchTaken=1, EX_RegWrite=1, EX_RegRd=8, ID_RegRt=8, ID_UsesRt=1 -> the first cycle has stall=1 and IFID_Flush=0; after EX moves on, IFID_Flush=1 for one cycle.
REQ-031 SHALL cover mul/div with MD_LATENCY=4: ID_MulDiv=1 held -> MD_Start for one cycle, 4 stall cycles total, MD_Busy for 3 cycles, then DONE releases the instruction, the FSM returns to IDLE, and there is no second MD_Start.
REQ-032 SHALL cover register 0: EX_MemRead=1, EX_RegRd=0, ID_RegRs=0 -> no stall.
REQ-033 SHALL cover saturation: force 70000 stall cycles -> StallCount holds at 16'hFFFF.
REQ-034 SHALL cover reset mid-BUSY: drive rst_i low for 1 cycle -> MD_Busy=0 immediately, state IDLE and StallCount=0.
